// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encoding, register-index width and watchdog defaults.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W_DEF   = 5;
    localparam int WAIT_TIMEOUT_DEF = 255;
    localparam int WDOG_W           = 8;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        RUN       = 2'd1,
        IMEM_WAIT = 2'd2,
        DMEM_WAIT = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master: drives hazard sources and
// memory handshakes) and the hazard controller (slave: drives PC enable,
// per-stage stall/flush controls and status).
interface pipeline_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
);
    logic                  JalD;
    logic                  BranchE;
    logic                  JalrE;
    logic                  MemToRegE;
    logic [REG_ADDR_W-1:0] RdE;
    logic [REG_ADDR_W-1:0] Rs1D;
    logic [REG_ADDR_W-1:0] Rs2D;
    logic                  imem_ready;
    logic                  dmem_req_M;
    logic                  dmem_ready;

    logic                  PCEn;
    logic                  StallD, StallE, StallM, StallW;
    logic                  FlushD, FlushE, FlushM, FlushW;
    logic                  mem_timeout;
    logic [1:0]            state_o;

    modport master (
        output JalD, BranchE, JalrE, MemToRegE, RdE, Rs1D, Rs2D,
               imem_ready, dmem_req_M, dmem_ready,
        input  PCEn, StallD, StallE, StallM, StallW,
               FlushD, FlushE, FlushM, FlushW, mem_timeout, state_o
    );

    modport slave (
        input  JalD, BranchE, JalrE, MemToRegE, RdE, Rs1D, Rs2D,
               imem_ready, dmem_req_M, dmem_ready,
        output PCEn, StallD, StallE, StallM, StallW,
               FlushD, FlushE, FlushM, FlushW, mem_timeout, state_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds
// either ID source operand. x0 is hardwired zero and never creates a hazard.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  memToRegE,
    input  logic [REG_ADDR_W-1:0] rdE,
    input  logic [REG_ADDR_W-1:0] rs1D,
    input  logic [REG_ADDR_W-1:0] rs2D,
    output logic                  loadUse
);

    assign loadUse = memToRegE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline.
// Mealy outputs from a small FSM (post-reset hold, fetch wait, data wait)
// plus a sticky watchdog on data-memory waits.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush/load-use counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF,
    parameter int REG_ADDR_W   = REG_ADDR_W_DEF
) (
    input  logic clk,
    input  logic clear,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
    output logic [31:0] lu_bubbles,
`endif
    pipeline_hazard_ctrl_if.slave hz
);

    ctrl_state_e       state, stateNext;
    logic [WDOG_W-1:0] wdogCnt;
    logic [WDOG_W:0]   wdogInc;
    logic              timeoutReg;

    logic loadUse;
    logic dmemStall;
    logic exRedirect;
    logic pcEn;
    logic stallD, stallE, stallM, stallW;
    logic flushD, flushE, flushM, flushW;

    hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) uHazardDetect (
        .memToRegE (hz.MemToRegE),
        .rdE       (hz.RdE),
        .rs1D      (hz.Rs1D),
        .rs2D      (hz.Rs2D),
        .loadUse   (loadUse)
    );

    assign dmemStall  = hz.dmem_req_M && !hz.dmem_ready;
    assign exRedirect = hz.BranchE || hz.JalrE;
    assign wdogInc    = {1'b0, wdogCnt} + {{WDOG_W{1'b0}}, 1'b1};

    // State register: clear parks the FSM in the one-cycle HOLD state.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= HOLD;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and stall/flush decode. RUN, IMEM_WAIT and DMEM_WAIT share
    // one priority chain: in DMEM_WAIT a still-pending access keeps all
    // stages frozen, and the completing cycle falls through to the normal
    // redirect/load-use/fetch rules so held redirects are acted on at once.
    always_comb begin
        stateNext = state;
        pcEn      = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        stallW    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        flushW    = 1'b0;
        if (clear) begin
            stateNext = HOLD;
            {flushD, flushE, flushM, flushW} = 4'b1111;
        end else begin
            unique case (state)
                HOLD: begin
                    {flushD, flushE, flushM, flushW} = 4'b1111;
                    stateNext = RUN;
                end
                default: begin
                    if (dmemStall) begin
                        {stallD, stallE, stallM, stallW} = 4'b1111;
                        stateNext = DMEM_WAIT;
                    end else if (exRedirect) begin
                        pcEn      = 1'b1;
                        flushD    = 1'b1;
                        flushE    = 1'b1;
                        stateNext = RUN;
                    end else if (loadUse) begin
                        stallD    = 1'b1;
                        flushE    = 1'b1;
                        // A pending fetch stays pending across the bubble.
                        stateNext = (state == IMEM_WAIT && !hz.imem_ready) ? IMEM_WAIT : RUN;
                    end else if (hz.JalD) begin
                        pcEn      = 1'b1;
                        flushD    = 1'b1;
                        stateNext = RUN;
                    end else if (!hz.imem_ready) begin
                        flushD    = 1'b1;
                        stateNext = IMEM_WAIT;
                    end else begin
                        pcEn      = 1'b1;
                        stateNext = RUN;
                    end
                end
            endcase
        end
    end

    // Watchdog: count stalled DMEM_WAIT cycles, latch a sticky timeout flag.
    always_ff @(posedge clk) begin
        if (clear) begin
            wdogCnt    <= '0;
            timeoutReg <= 1'b0;
        end else if (state == DMEM_WAIT && dmemStall) begin
            if (wdogCnt != {WDOG_W{1'b1}}) begin
                wdogCnt <= wdogInc[WDOG_W-1:0];
            end
            if (wdogInc >= (WDOG_W+1)'(WAIT_TIMEOUT)) begin
                timeoutReg <= 1'b1;
            end
        end else begin
            wdogCnt <= '0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic redirectAct;
    logic luAct;

    assign redirectAct = !clear && (state != HOLD) && !dmemStall &&
                         (exRedirect || (!loadUse && hz.JalD));
    assign luAct       = !clear && (state != HOLD) && !dmemStall && !exRedirect && loadUse;

    // Performance counters, free-running and wrapping.
    always_ff @(posedge clk) begin
        if (clear) begin
            stall_cycles <= '0;
            flush_events <= '0;
            lu_bubbles   <= '0;
        end else begin
            if (!pcEn && state != HOLD) stall_cycles <= stall_cycles + 32'd1;
            if (redirectAct)            flush_events <= flush_events + 32'd1;
            if (luAct)                  lu_bubbles   <= lu_bubbles + 32'd1;
        end
    end
`else
    // Counters are not built; no extra ports or state.
`endif

    assign hz.PCEn        = pcEn;
    assign hz.StallD      = stallD;
    assign hz.StallE      = stallE;
    assign hz.StallM      = stallM;
    assign hz.StallW      = stallW;
    assign hz.FlushD      = flushD;
    assign hz.FlushE      = flushE;
    assign hz.FlushM      = flushM;
    assign hz.FlushW      = flushW;
    assign hz.mem_timeout = timeoutReg && !clear;
    assign hz.state_o     = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed
// by randomized traffic, all compared cycle by cycle against a rule-level
// reference model of the stall/flush behaviour.
module tb_pipeline_hazard_ctrl;

    localparam int RW = 5;
    localparam int TO = 3;

    logic clk = 1'b0;
    logic clear;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: pending hold, waiting on fetch, waiting on data,
    // consecutive stalled data-wait cycles and the sticky timeout.
    bit   mHold  = 1'b0;
    bit   mFetch = 1'b0;
    bit   mData  = 1'b0;
    bit   mTo    = 1'b0;
    int   mWait  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(RW)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCycles, flushEvents, luBubbles;
    pipeline_hazard_ctrl #(.WAIT_TIMEOUT(TO), .REG_ADDR_W(RW)) dut (
        .clk(clk), .clear(clear),
        .stall_cycles(stallCycles), .flush_events(flushEvents), .lu_bubbles(luBubbles),
        .hz(bus)
    );
`else
    pipeline_hazard_ctrl #(.WAIT_TIMEOUT(TO), .REG_ADDR_W(RW)) dut (
        .clk(clk), .clear(clear), .hz(bus)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit clr, input bit jalD, input bit br, input bit jalr,
                         input bit m2r, input int rd, input int rs1, input int rs2,
                         input bit iRdy, input bit dReq, input bit dRdy);
        clear          = clr;
        bus.JalD       = jalD;
        bus.BranchE    = br;
        bus.JalrE      = jalr;
        bus.MemToRegE  = m2r;
        bus.RdE        = RW'(rd);
        bus.Rs1D       = RW'(rs1);
        bus.Rs2D       = RW'(rs2);
        bus.imem_ready = iRdy;
        bus.dmem_req_M = dReq;
        bus.dmem_ready = dRdy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 1, 2, 3, 1, 0, 0);
    endtask

    // Check outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        bit       ePc, eTo, lu;
        bit [3:0] eSt, eFl;
        int       eState;
        @(negedge clk);
        ePc = 0; eSt = 4'h0; eFl = 4'h0; eTo = mTo; eState = -1;
        lu  = bus.MemToRegE && (bus.RdE != 0) && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
        if (clear) begin
            eFl = 4'hF; eTo = 0;
            mHold = 1; mFetch = 0; mData = 0; mWait = 0; mTo = 0;
        end else if (mHold) begin
            eFl = 4'hF; eState = 0; mHold = 0;
        end else begin
            eState = mData ? 3 : (mFetch ? 2 : 1);
            if (bus.dmem_req_M && !bus.dmem_ready) begin
                eSt = 4'hF;
                if (mData) begin
                    mWait++;
                    if (mWait >= TO) mTo = 1;
                end
                mData = 1; mFetch = 0;
            end else begin
                mData = 0; mWait = 0;
                if (bus.BranchE || bus.JalrE) begin
                    ePc = 1; eFl = 4'b1100; mFetch = 0;
                end else if (lu) begin
                    eSt = 4'b1000; eFl = 4'b0100; mFetch = mFetch && !bus.imem_ready;
                end else if (bus.JalD) begin
                    ePc = 1; eFl = 4'b1000; mFetch = 0;
                end else if (!bus.imem_ready) begin
                    eFl = 4'b1000; mFetch = 1;
                end else begin
                    ePc = 1; mFetch = 0;
                end
            end
        end
        chk("pcen", 32'(bus.PCEn), 32'(ePc));
        chk("stall", 32'({bus.StallD, bus.StallE, bus.StallM, bus.StallW}), 32'(eSt));
        chk("flush", 32'({bus.FlushD, bus.FlushE, bus.FlushM, bus.FlushW}), 32'(eFl));
        chk("timeout", 32'(bus.mem_timeout), 32'(eTo));
        if (eState >= 0) chk("state", 32'(bus.state_o), 32'(eState));
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int r;
        drive(1, 0, 0, 0, 0, 1, 2, 3, 1, 0, 0);
        // Reset for two cycles, one HOLD cycle, then normal fetch.
        run(2);
        idle();
        run(3);

        // Load-use on Rs2, then the same pattern through x0.
        drive(0, 0, 0, 0, 1, 5, 7, 5, 1, 0, 0); cycle();
        idle(); cycle();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0); cycle();
        idle(); cycle();

        // Branch beats load-use and JAL together.
        drive(0, 1, 1, 0, 1, 6, 6, 9, 1, 0, 0); cycle();
        drive(0, 1, 0, 1, 1, 6, 6, 9, 0, 0, 0); cycle();
        idle(); cycle();

        // Fetch wait of three cycles, then ready.
        drive(0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0); run(3);
        idle(); run(2);
        // Fetch wait interrupted by JAL on its second cycle.
        drive(0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0); cycle();
        drive(0, 1, 0, 0, 0, 1, 2, 3, 0, 0, 0); cycle();
        idle(); run(2);

        // Data wait with a branch held in EX, then release and the branch.
        drive(0, 0, 1, 0, 0, 1, 2, 3, 1, 1, 0); run(4);
        drive(0, 0, 1, 0, 0, 1, 2, 3, 1, 1, 1); cycle();
        idle(); run(2);
        // Request dropped without ready counts as completion.
        drive(0, 0, 0, 0, 0, 1, 2, 3, 1, 1, 0); run(2);
        drive(0, 0, 0, 0, 0, 1, 2, 3, 1, 0, 0); run(2);

        // Long data wait trips the watchdog; flag sticks until clear.
        drive(0, 0, 0, 0, 0, 1, 2, 3, 1, 1, 0); run(6);
        drive(0, 0, 0, 0, 0, 1, 2, 3, 1, 1, 1); cycle();
        idle(); run(4);
        drive(1, 0, 0, 0, 0, 1, 2, 3, 1, 0, 0); cycle();
        idle(); run(3);

        // Randomized traffic with small register indices to provoke matches.
        for (int i = 0; i < 4000; i++) begin
            bit dReq;
            r    = int'($urandom_range(0, 99));
            dReq = ($urandom_range(0, 99) < 30);
            drive(r < 2,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 35,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 75,
                  dReq,
                  $urandom_range(0, 99) < 45);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It drives the PC generator's enable and the per-stage register stall/flush controls from four sources: redirect requests (JAL in ID; branch/JALR in EX), load-use hazards, instruction-memory wait states and data-memory wait states. A small FSM tracks multi-cycle memory waits and a post-reset hold. A watchdog flags data-memory waits that never complete.

Parameters:
WAIT_TIMEOUT, 255, max consecutive DMEM_WAIT cycles before mem_timeout is set (8-bit counter, range 1..255)
REG_ADDR_W, 5, register-index width

Ports:
clk  in  1  clock
clear  in  1  synchronous active-high reset
JalD  in  1  JAL decoded in ID
BranchE  in  1  taken branch resolved in EX
JalrE  in  1  JALR in EX
MemToRegE  in  1  EX instruction is a load
RdE  in  REG_ADDR_W  EX destination register
Rs1D  in  REG_ADDR_W  ID source 1
Rs2D  in  REG_ADDR_W  ID source 2
imem_ready  in  1  fetch data valid this cycle
dmem_req_M  in  1  MEM-stage load/store active
dmem_ready  in  1  data memory completes this cycle
PCEn  out  1  enable to PC generator
StallD, StallE, StallM, StallW  out  1 each  hold stage register
FlushD, FlushE, FlushM, FlushW  out  1 each  bubble stage register
mem_timeout  out  1  sticky watchdog flag
state_o  out  2  current FSM state (debug)

Behaviour:
- Clock is clk; reset is clear, synchronous and active-high. Outputs are combinational (Mealy) from the state register and inputs; only the state, watchdog counter and mem_timeout are registered.
- While clear=1: PCEn=0, all Stall*=0, all Flush*=1, mem_timeout=0. On the next edge the state becomes HOLD.
- State encoding: HOLD=0, RUN=1, IMEM_WAIT=2, DMEM_WAIT=3.
- HOLD (exactly 1 cycle): PCEn=0; FlushD/E/M/W=1. Next state is RUN.
- RUN: signals are evaluated in this priority order.
  1. DMEM stall: dmem_req_M & ~dmem_ready -> PCEn=0; StallD/E/M/W=1; no flush; next state DMEM_WAIT. Redirect inputs are ignored here; they stay held in the frozen EX/ID.
  2. EX redirect: BranchE | JalrE -> PCEn=1; FlushD=FlushE=1. This overrides load-use and JalD.
  3. Load-use: MemToRegE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D) -> PCEn=0; StallD=1; FlushE=1. Exactly one bubble.
  4. JalD -> PCEn=1; FlushD=1.
  5. Fetch wait: ~imem_ready -> PCEn=0; FlushD=1 (bubble into ID); next state IMEM_WAIT.
  6. Otherwise PCEn=1 and all stall/flush outputs are 0.
- When a redirect (cases 2 or 4) coincides with ~imem_ready, the redirect wins: PCEn=1, the fetch is abandoned, and the state stays RUN.
- IMEM_WAIT: same priority as RUN for cases 1–4.
  - imem_ready=1 with no higher case -> PCEn=1, next state RUN.
  - Any redirect -> PCEn=1, next state RUN.
  - Otherwise PCEn=0, FlushD=1, stay in IMEM_WAIT.
- DMEM_WAIT: PCEn=0; StallD/E/M/W=1.
  - dmem_ready=1 -> release all stalls this cycle, next state RUN.
  - A dmem_req_M drop without ready is treated as completion.
- Watchdog: an 8-bit counter increments each DMEM_WAIT cycle and clears on leaving DMEM_WAIT. When it reaches WAIT_TIMEOUT, mem_timeout is set; it stays set until clear. The state is unaffected.
- Register x0 never causes a load-use hazard.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: adds 32-bit outputs stall_cycles, flush_events and lu_bubbles, wrapping at 2^32 and cleared by clear.
  - stall_cycles counts cycles with PCEn=0 outside HOLD.
  - flush_events counts cycles with a redirect.
  - lu_bubbles counts load-use cycles.
- Undefined: these ports and counters do not exist.

Decomposition:
- Shared package pipe_ctrl_pkg: state encoding constants (HOLD/RUN/IMEM_WAIT/DMEM_WAIT), REG_ADDR_W, WAIT_TIMEOUT default.
- One natural sub-module: hazard_detect, the combinational load-use comparator.

Test Plan:
- clear=1 for 2 cycles, then released -> PCEn=0 and Flush*=1 during clear and for 1 HOLD cycle, then PCEn=1 and state_o=1.
- Load-use: MemToRegE=1, RdE=5, Rs2D=5 -> 1 cycle of PCEn=0, StallD=1, FlushE=1; same with RdE=0 -> no stall.
- BranchE=1 together with a load-use match and JalD=1 -> PCEn=1, FlushD=FlushE=1, StallD=0.
- imem_ready=0 for 3 cycles -> state_o=2, PCEn=0, FlushD=1 each cycle; ready on 4th -> PCEn=1, state RUN. Repeat with JalD=1 on cycle 2 -> immediate exit, PCEn=1.
- dmem_req_M=1, dmem_ready=0 for 4 cycles with BranchE=1 -> all stalls high, PCEn=0, no flush; ready -> release, then BranchE acted on.
- WAIT_TIMEOUT=3, dmem wait of 5 cycles -> mem_timeout rises after 3 wait cycles and stays set until clear.
